// File: rtl/cntr_cla_n.sv
// Parametrised up/down counter with load, programmable modulus and wrap/saturate.
// The +1 / -1 goes through a WIDTH-bit adder made of chained 4-bit carry-lookahead blocks.
module cntr_cla_n #(
  parameter int WIDTH = 8  // multiple of 4, at least 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_load,
  input  logic             i_sat,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_max,
  output logic [WIDTH-1:0] o_cnt,
  output logic [1:0]       o_state,
  output logic             o_tc
);

  localparam int NB = WIDTH / 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_INC  = 2'b01;
  localparam logic [1:0] ST_DEC  = 2'b10;
  localparam logic [1:0] ST_LOAD = 2'b11;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_ci;
  logic [NB-1:0]    blk_ci;
  logic             add_co_unused;

  always_comb begin
    state_d = ST_IDLE;
    if (i_load) begin
      state_d = ST_LOAD;
    end else if (i_inc && !i_dec) begin
      state_d = ST_INC;
    end else if (i_dec && !i_inc) begin
      state_d = ST_DEC;
    end
  end

  // Increment: b = 0, ci = 1.  Decrement: b = all-ones, ci = 0.
  assign add_b     = (state_d == ST_DEC) ? '1 : '0;
  assign add_ci    = (state_d == ST_INC);
  assign blk_ci[0] = add_ci;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_cla
      logic [3:0] a, b, p, g;
      logic       c0, c1, c2, c3, c4;

      assign a  = cnt_q[4*gi +: 4];
      assign b  = add_b[4*gi +: 4];
      assign p  = a ^ b;
      assign g  = a & b;
      assign c0 = blk_ci[gi];
      assign c1 = g[0] | (p[0] & c0);
      assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);
      assign add_sum[4*gi +: 4] = p ^ {c3, c2, c1, c0};

      if (gi < NB - 1) begin : g_mid
        assign blk_ci[gi+1] = c4;
      end else begin : g_last
        assign add_co_unused = c4;
      end
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    case (state_d)
      ST_LOAD: cnt_d = (i_d <= i_max) ? i_d : i_max;
      ST_INC: begin
        // A count above a freshly lowered i_max also counts as the boundary.
        if (cnt_q >= i_max) begin
          cnt_d = i_sat ? i_max : '0;
          tc_d  = 1'b1;
        end else begin
          cnt_d = add_sum;
        end
      end
      ST_DEC: begin
        if (cnt_q == '0) begin
          cnt_d = i_sat ? '0 : i_max;
          tc_d  = 1'b1;
        end else begin
          cnt_d = add_sum;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  assign o_cnt   = cnt_q;
  assign o_state = state_q;
  assign o_tc    = tc_q;

endmodule

// File: tb/tb_cntr_cla_n.sv
// Scoreboard bench for cntr_cla_n: an 8-bit and a 16-bit instance share the command inputs.
module tb_cntr_cla_n;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_inc = 1'b0, i_dec = 1'b0, i_load = 1'b0, i_sat = 1'b0;
  logic [7:0]  d8 = 8'h00, max8 = 8'hFF;
  logic [15:0] d16 = 16'h0000, max16 = 16'hFFFF;
  logic [7:0]  cnt8;
  logic [15:0] cnt16;
  logic [1:0]  st8, st16;
  logic        tc8, tc16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w16;
    logic [15:0] cnt;
    logic [1:0]  st;
    logic        tc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  always #5 clk = ~clk;

  cntr_cla_n #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .i_inc(i_inc), .i_dec(i_dec), .i_load(i_load),
    .i_sat(i_sat), .i_d(d8), .i_max(max8), .o_cnt(cnt8), .o_state(st8), .o_tc(tc8)
  );

  cntr_cla_n #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .i_inc(i_inc), .i_dec(i_dec), .i_load(i_load),
    .i_sat(i_sat), .i_d(d16), .i_max(max16), .o_cnt(cnt16), .o_state(st16), .o_tc(tc16)
  );

  // Drive one command, push its expected result, then capture what the DUT shows after the edge.
  task automatic apply(input logic w16, input logic ld, input logic inc, input logic dec,
                       input logic sat, input logic [15:0] d, input logic [15:0] mx,
                       input logic [15:0] ecnt, input logic [1:0] est, input logic etc);
    rec_t e, o;
    i_load = ld; i_inc = inc; i_dec = dec; i_sat = sat;
    if (w16) begin
      d16 = d; max16 = mx;
    end else begin
      d8 = d[7:0]; max8 = mx[7:0];
    end
    e.w16 = w16; e.cnt = ecnt; e.st = est; e.tc = etc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.w16 = w16;
    o.cnt = w16 ? cnt16 : {8'h00, cnt8};
    o.st  = w16 ? st16 : st8;
    o.tc  = w16 ? tc16 : tc8;
    obs_q.push_back(o);
    $display("step w16=%0d ld=%0d inc=%0d dec=%0d sat=%0d d=%h max=%h -> cnt=%h st=%0d tc=%0d",
             w16, ld, inc, dec, sat, d, mx, o.cnt, o.st, o.tc);
  endtask

  task automatic test_reset;
    rec_t e, o;
    int n;
    #1 reset = 1'b1;
    #2;
    checks++; if (cnt8 !== 8'h00)   begin errors++; $display("FAIL reset_init cnt8: got %h expected 00", cnt8); end
    checks++; if (st8 !== 2'b00)    begin errors++; $display("FAIL reset_init st8: got %b expected 00", st8); end
    checks++; if (tc8 !== 1'b0)     begin errors++; $display("FAIL reset_init tc8: got %b expected 0", tc8); end
    checks++; if (cnt16 !== 16'h0)  begin errors++; $display("FAIL reset_init cnt16: got %h expected 0000", cnt16); end
    @(posedge clk);
    #1 reset = 1'b0;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0037, 16'h00FF, 16'h0037, 2'b11, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, 16'h0036, 2'b10, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h00FF, 16'h0037, 2'b01, 1'b0);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o.cnt !== e.cnt) begin errors++; $display("FAIL reset_pre step %0d cnt: got %h expected %h", n, o.cnt, e.cnt); end
      checks++; if (o.st !== e.st)   begin errors++; $display("FAIL reset_pre step %0d state: got %b expected %b", n, o.st, e.st); end
      checks++; if (o.tc !== e.tc)   begin errors++; $display("FAIL reset_pre step %0d tc: got %b expected %b", n, o.tc, e.tc); end
    end
    // Mid-count asynchronous reset, checked before any further clock edge.
    #3 reset = 1'b1;
    #1;
    checks++; if (cnt8 !== 8'h00) begin errors++; $display("FAIL reset_async cnt: got %h expected 00", cnt8); end
    checks++; if (st8 !== 2'b00)  begin errors++; $display("FAIL reset_async state: got %b expected 00", st8); end
    checks++; if (tc8 !== 1'b0)   begin errors++; $display("FAIL reset_async tc: got %b expected 0", tc8); end
    i_inc = 1'b0;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    $display("reset checks done");
  endtask

  task automatic test_wrap_up;
    rec_t e, o;
    int n;
    for (int i = 1; i <= 12; i++)
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd9, 16'(i % 10), 2'b01, (i == 10));
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o.cnt !== e.cnt) begin errors++; $display("FAIL wrap_up step %0d cnt: got %h expected %h", n, o.cnt, e.cnt); end
      checks++; if (o.st !== e.st)   begin errors++; $display("FAIL wrap_up step %0d state: got %b expected %b", n, o.st, e.st); end
      checks++; if (o.tc !== e.tc)   begin errors++; $display("FAIL wrap_up step %0d tc: got %b expected %b", n, o.tc, e.tc); end
    end
  endtask

  task automatic test_sat_down;
    rec_t e, o;
    int n;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h00FF, 16'h0001, 2'b11, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, 16'h0000, 2'b10, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, 16'h0000, 2'b10, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, 16'h0000, 2'b10, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00FF, 16'h00FF, 2'b10, 1'b1);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o.cnt !== e.cnt) begin errors++; $display("FAIL sat_down step %0d cnt: got %h expected %h", n, o.cnt, e.cnt); end
      checks++; if (o.st !== e.st)   begin errors++; $display("FAIL sat_down step %0d state: got %b expected %b", n, o.st, e.st); end
      checks++; if (o.tc !== e.tc)   begin errors++; $display("FAIL sat_down step %0d tc: got %b expected %b", n, o.tc, e.tc); end
    end
  endtask

  task automatic test_load_clamp;
    rec_t e, o;
    int n;
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd200, 16'd100, 16'd100, 2'b11, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,   16'd100, 16'd0,   2'b01, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd42,  16'd100, 16'd42,  2'b11, 1'b0);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o.cnt !== e.cnt) begin errors++; $display("FAIL load_clamp step %0d cnt: got %h expected %h", n, o.cnt, e.cnt); end
      checks++; if (o.st !== e.st)   begin errors++; $display("FAIL load_clamp step %0d state: got %b expected %b", n, o.st, e.st); end
      checks++; if (o.tc !== e.tc)   begin errors++; $display("FAIL load_clamp step %0d tc: got %b expected %b", n, o.tc, e.tc); end
    end
  endtask

  task automatic test_simul_carry;
    rec_t e, o;
    int n;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000F, 16'h00FF, 16'h000F, 2'b11, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h00FF, 16'h000F, 2'b00, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00FF, 16'h0010, 2'b01, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h007F, 16'h00FF, 16'h007F, 2'b11, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00FF, 16'h0080, 2'b01, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00FF, 16'h007F, 2'b10, 1'b0);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o.cnt !== e.cnt) begin errors++; $display("FAIL simul_carry step %0d cnt: got %h expected %h", n, o.cnt, e.cnt); end
      checks++; if (o.st !== e.st)   begin errors++; $display("FAIL simul_carry step %0d state: got %b expected %b", n, o.st, e.st); end
      checks++; if (o.tc !== e.tc)   begin errors++; $display("FAIL simul_carry step %0d tc: got %b expected %b", n, o.tc, e.tc); end
    end
  endtask

  task automatic test_max_change;
    rec_t e, o;
    int n;
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 2'b01, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h00FF, 16'h0050, 2'b11, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h004F, 2'b10, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0010, 16'h0010, 2'b01, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'b10, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2'b10, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o.cnt !== e.cnt) begin errors++; $display("FAIL max_change step %0d cnt: got %h expected %h", n, o.cnt, e.cnt); end
      checks++; if (o.st !== e.st)   begin errors++; $display("FAIL max_change step %0d state: got %b expected %b", n, o.st, e.st); end
      checks++; if (o.tc !== e.tc)   begin errors++; $display("FAIL max_change step %0d tc: got %b expected %b", n, o.tc, e.tc); end
    end
  endtask

  task automatic test_width16;
    rec_t e, o;
    int n;
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0FFF, 16'hFFFF, 16'h0FFF, 2'b11, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h1000, 2'b01, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b11, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 2'b01, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 2'b10, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFE, 2'b10, 1'b0);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o.cnt !== e.cnt) begin errors++; $display("FAIL width16 step %0d cnt: got %h expected %h", n, o.cnt, e.cnt); end
      checks++; if (o.st !== e.st)   begin errors++; $display("FAIL width16 step %0d state: got %b expected %b", n, o.st, e.st); end
      checks++; if (o.tc !== e.tc)   begin errors++; $display("FAIL width16 step %0d tc: got %b expected %b", n, o.tc, e.tc); end
    end
  endtask

  // Random command stream against a behavioural reference using plain +1/-1 arithmetic.
  task automatic test_back_to_back;
    rec_t e, o;
    int n;
    int m_cnt, mx, dv, sel;
    logic ld, inc, dec, sat, tc;
    logic [1:0] st;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00FF, 16'h0000, 2'b11, 1'b0);
    m_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 3);
      mx  = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(1, 254);
      dv  = $urandom_range(0, 255);
      ld  = ($urandom_range(0, 7) == 0);
      inc = $urandom_range(0, 1);
      dec = $urandom_range(0, 1);
      sat = $urandom_range(0, 1);
      tc  = 1'b0;
      if (ld) begin
        st = 2'b11; m_cnt = (dv > mx) ? mx : dv;
      end else if (inc && !dec) begin
        st = 2'b01;
        if (m_cnt >= mx) begin m_cnt = sat ? mx : 0; tc = 1'b1; end
        else m_cnt = m_cnt + 1;
      end else if (dec && !inc) begin
        st = 2'b10;
        if (m_cnt == 0) begin m_cnt = sat ? 0 : mx; tc = 1'b1; end
        else m_cnt = m_cnt - 1;
      end else begin
        st = 2'b00;
      end
      apply(1'b0, ld, inc, dec, sat, 16'(dv), 16'(mx), 16'(m_cnt), st, tc);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o.cnt !== e.cnt) begin errors++; $display("FAIL back_to_back step %0d cnt: got %h expected %h", n, o.cnt, e.cnt); end
      checks++; if (o.st !== e.st)   begin errors++; $display("FAIL back_to_back step %0d state: got %b expected %b", n, o.st, e.st); end
      checks++; if (o.tc !== e.tc)   begin errors++; $display("FAIL back_to_back step %0d tc: got %b expected %b", n, o.tc, e.tc); end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_simul_carry();
    test_max_change();
    test_width16();
    test_back_to_back();
    i_inc = 1'b0; i_dec = 1'b0; i_load = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cntr_cla_n.md
# cntr_cla_n

Parametrised up/down counter with synchronous load, programmable modulus and selectable wrap/saturate behaviour. It is the generalised successor of the 8-bit counter and replaces it wherever a counter of arbitrary width is needed. Increment and decrement use a WIDTH-bit carry-lookahead adder built from 4-bit CLA blocks, with the carry-in carrying the +1. A 2-bit FSM records the operation performed on each clock.

## Interface
- WIDTH, 8, counter width in bits; must be a multiple of 4 and at least 4.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-high.
- i_inc  input  1  increment request.
- i_dec  input  1  decrement request.
- i_load  input  1  load request; has priority over i_inc and i_dec.
- i_sat  input  1  1 = saturate at the boundaries, 0 = wrap around.
- i_d  input  WIDTH  value to load.
- i_max  input  WIDTH  modulus limit; legal counts are 0..i_max.
- o_cnt  output  WIDTH  registered count.
- o_state  output  2  registered FSM state: IDLE=2'b00, INC=2'b01, DEC=2'b10, LOAD=2'b11.
- o_tc  output  1  registered terminal-count flag.

## Operation
- Each rising clk edge evaluates the command in priority order:
  - i_load → LOAD.
  - i_inc & i_dec both high → IDLE.
  - i_inc alone → INC.
  - i_dec alone → DEC.
  - No request → IDLE.
- o_state takes the next state on the same edge. o_cnt is updated according to that next state.
- IDLE: o_cnt holds its value.
- LOAD: o_cnt ← i_d if i_d ≤ i_max, otherwise o_cnt ← i_max (clamp). o_tc is not set by a load.
- INC:
  - If o_cnt < i_max: o_cnt ← o_cnt + 1, computed as the CLA sum with b = 0 and ci = 1.
  - If o_cnt ≥ i_max (boundary): o_cnt ← 0 when i_sat = 0, o_cnt ← i_max when i_sat = 1. o_tc is set.
- DEC:
  - If o_cnt ≠ 0: o_cnt ← o_cnt − 1, computed as the CLA sum o_cnt + all-ones with ci = 0. The carry-out is discarded.
  - If o_cnt = 0 (boundary): o_cnt ← i_max when i_sat = 0, o_cnt stays 0 when i_sat = 1. o_tc is set.
- o_tc is high for exactly the cycle following a boundary event and is cleared otherwise. A repeated boundary event in saturate mode keeps o_tc high on every such cycle.
- i_max may change at any time and takes effect at the next edge:
  - If o_cnt is above the new i_max, the next INC is treated as a boundary event.
  - DEC from above i_max decrements normally.
- i_max = 0: every INC and every DEC is a boundary event. o_cnt stays 0 in both wrap and saturate modes.
- i_max = all-ones: the counter behaves as a plain modulo-2^WIDTH counter in wrap mode.

## Timing
- Reset (async, any time, including mid-operation): o_cnt = 0, o_state = IDLE, o_tc = 0 immediately.
- After reset deasserts, the first edge is processed normally.
- Latency: a command sampled at edge N is visible on o_cnt, o_state and o_tc after edge N. There is one-cycle latency and a throughput of one operation per cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The adder path is purely combinational between registers and is a single-cycle path.

## Test plan
- Reset check: assert reset mid-count with o_cnt = 8'h37 → o_cnt = 0, o_state = 2'b00, o_tc = 0 immediately without a clock edge.
- Wrap-up: WIDTH = 8, i_max = 8'd9, i_sat = 0, i_inc held for 12 cycles from 0 → sequence 1..9, 0, 1, 2; o_tc high only in the cycle showing 0.
- Saturate/down: i_max = 8'hFF, i_sat = 1, load 8'h01, then 3 decrements → o_cnt 0, 0, 0 with o_tc high on the 2nd and 3rd. Then i_sat = 0 with one decrement → 8'hFF and o_tc = 1.
- Load clamp and priority: i_max = 8'd100, i_load = i_inc = 1, i_d = 8'd200 → o_cnt = 8'd100, o_state = LOAD, o_tc = 0. Then i_inc alone with wrap → 0 and o_tc = 1.
- Simultaneous and carry chain: i_inc = i_dec = 1 at o_cnt = 8'h0F → o_cnt holds 8'h0F, o_state = IDLE. Then an increment gives 8'h10, and from 8'h7F an increment gives 8'h80, exercising CLA block carry propagation.
- Width scaling: WIDTH = 16, i_max = 16'hFFFF, load 16'h0FFF then increment → 16'h1000. Load 16'hFFFF then increment (wrap) → 16'h0000 with o_tc = 1.
